// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//
// Shares one single-port, byte-writeable, synchronous-read 16-bit data memory
// between master 0 (CPU data port) and master 1 (loader / debug / DMA).
// Master 0 has fixed priority. Either master can hold the bus across several
// transactions with its lock input. Read data is routed back to the master
// that issued the read, one cycle after acceptance.
//
// Optional feature: define MEM_ARB_STARVE_GUARD_EN to add a wait counter for
// master 1. When master 1 has waited MAX_WAIT cycles it overrides master 0,
// including breaking a master-0 lock.
//
// Parameters
//   MAX_WAIT        cycles master 1 may wait before the guard forces its grant (1..255)
// Ports
//   clk, rst        clock, synchronous active-high reset
//   mX_req          transaction request
//   mX_lock         keep ownership after this transaction
//   mX_addr         byte address
//   mX_wdata        write data
//   mX_oe           read request
//   mX_we           byte write enables ([1] -> mem_we1, [0] -> mem_we0)
//   mX_gnt          transaction accepted this cycle (combinational)
//   mX_rvalid       read data valid on mX_rdata
//   mX_rdata        read data (0 when mX_rvalid is low)
//   mem_addr/din    memory address / write data
//   mem_dout        memory read data, valid one cycle after mem_oe
//   mem_oe/we0/we1  memory controls

module mem_port_arbiter #(
    parameter int unsigned MAX_WAIT = 8
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        m0_req,
    input  logic        m0_lock,
    input  logic [15:0] m0_addr,
    input  logic [15:0] m0_wdata,
    input  logic        m0_oe,
    input  logic [1:0]  m0_we,
    output logic        m0_gnt,
    output logic        m0_rvalid,
    output logic [15:0] m0_rdata,

    input  logic        m1_req,
    input  logic        m1_lock,
    input  logic [15:0] m1_addr,
    input  logic [15:0] m1_wdata,
    input  logic        m1_oe,
    input  logic [1:0]  m1_we,
    output logic        m1_gnt,
    output logic        m1_rvalid,
    output logic [15:0] m1_rdata,

    output logic [15:0] mem_addr,
    output logic [15:0] mem_din,
    input  logic [15:0] mem_dout,
    output logic        mem_oe,
    output logic        mem_we0,
    output logic        mem_we1
);

    if (MAX_WAIT < 1 || MAX_WAIT > 255) begin : g_bad_max_wait
        $error("mem_port_arbiter: MAX_WAIT must be in 1..255");
    end

    typedef enum logic [1:0] {
        StIdle,
        StOwn0,
        StOwn1
    } state_e;

    state_e state_q, state_d;
    logic   guard_sat;
    logic   rvalid_q;
    logic   rsel_q;   // 0: outstanding read belongs to master 0, 1: master 1

    // ------------------------------------------------------------------
    // Starvation guard for master 1
    // ------------------------------------------------------------------
`ifdef MEM_ARB_STARVE_GUARD_EN
    logic [7:0] wait1_q, wait1_d;

    always_comb begin
        wait1_d = 8'd0;
        if (m1_req && !m1_gnt) begin
            wait1_d = (wait1_q == 8'(MAX_WAIT)) ? wait1_q : wait1_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wait1_q <= 8'd0;
        end else begin
            wait1_q <= wait1_d;
        end
    end

    // Only meaningful while master 1 is actually asking this cycle.
    assign guard_sat = m1_req && (wait1_q == 8'(MAX_WAIT));
`else
    assign guard_sat = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Grant and lock state
    // ------------------------------------------------------------------
    always_comb begin
        m0_gnt  = 1'b0;
        m1_gnt  = 1'b0;
        state_d = state_q;
        if (!rst) begin
            unique case (state_q)
                StIdle: begin
                    if (guard_sat) begin
                        m1_gnt = 1'b1;
                    end else if (m0_req) begin
                        m0_gnt = 1'b1;
                    end else if (m1_req) begin
                        m1_gnt = 1'b1;
                    end
                    if (m0_gnt && m0_lock) begin
                        state_d = StOwn0;
                    end else if (m1_gnt && m1_lock) begin
                        state_d = StOwn1;
                    end
                end
                StOwn0: begin
                    // A saturated guard breaks master 0's lock outright.
                    if (guard_sat) begin
                        m1_gnt  = 1'b1;
                        state_d = m1_lock ? StOwn1 : StIdle;
                    end else begin
                        m0_gnt = m0_req;
                        if (!m0_lock) begin
                            state_d = StIdle;
                        end
                    end
                end
                StOwn1: begin
                    m1_gnt = m1_req;
                    if (!m1_lock) begin
                        state_d = StIdle;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // Memory drive: mirror the granted master, zeros when nobody is granted
    // ------------------------------------------------------------------
    always_comb begin
        mem_addr = 16'h0000;
        mem_din  = 16'h0000;
        mem_oe   = 1'b0;
        mem_we0  = 1'b0;
        mem_we1  = 1'b0;
        if (m0_gnt) begin
            mem_addr = m0_addr;
            mem_din  = m0_wdata;
            mem_oe   = m0_oe && (m0_we == 2'b00);   // read+write: write wins
            mem_we0  = m0_we[0];
            mem_we1  = m0_we[1];
        end else if (m1_gnt) begin
            mem_addr = m1_addr;
            mem_din  = m1_wdata;
            mem_oe   = m1_oe && (m1_we == 2'b00);
            mem_we0  = m1_we[0];
            mem_we1  = m1_we[1];
        end
    end

    // ------------------------------------------------------------------
    // Read return routing
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            rvalid_q <= 1'b0;
            rsel_q   <= 1'b0;
        end else begin
            rvalid_q <= mem_oe;
            rsel_q   <= m1_gnt;
        end
    end

    // Masking with rst drops a read that was accepted just before reset.
    assign m0_rvalid = rvalid_q && !rsel_q && !rst;
    assign m1_rvalid = rvalid_q &&  rsel_q && !rst;
    assign m0_rdata  = m0_rvalid ? mem_dout : 16'h0000;
    assign m1_rdata  = m1_rvalid ? mem_dout : 16'h0000;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: directed scenarios followed by random traffic,
// checked against a behavioural model. Read responses go through a scoreboard
// queue consumed by an independent monitor.

module tb_mem_port_arbiter;

    localparam int unsigned MaxWait = 3;
`ifdef MEM_ARB_STARVE_GUARD_EN
    localparam bit Guard = 1'b1;
`else
    localparam bit Guard = 1'b0;
`endif

    logic        clk, rst;
    logic        m0_req, m0_lock, m0_oe, m0_gnt, m0_rvalid;
    logic [1:0]  m0_we;
    logic [15:0] m0_addr, m0_wdata, m0_rdata;
    logic        m1_req, m1_lock, m1_oe, m1_gnt, m1_rvalid;
    logic [1:0]  m1_we;
    logic [15:0] m1_addr, m1_wdata, m1_rdata;
    logic [15:0] mem_addr, mem_din, mem_dout;
    logic        mem_oe, mem_we0, mem_we1;

    mem_port_arbiter #(.MAX_WAIT(MaxWait)) dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_lock(m0_lock), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_oe(m0_oe), .m0_we(m0_we), .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid),
        .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_lock(m1_lock), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_oe(m1_oe), .m1_we(m1_we), .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid),
        .m1_rdata(m1_rdata),
        .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout),
        .mem_oe(mem_oe), .mem_we0(mem_we0), .mem_we1(mem_we1)
    );

    typedef struct packed {
        logic        req;
        logic        lock;
        logic        oe;
        logic [1:0]  we;
        logic [15:0] addr;
        logic [15:0] wdata;
    } mreq_t;

    typedef struct {
        int          m;
        logic [15:0] data;
        int          due;
    } exp_t;

    exp_t        sbq[$];
    exp_t        mon_e;
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    bit          started = 0;

    // Physical memory seen by the DUT and an independent model copy.
    logic [15:0] phys_mem [256];
    logic [15:0] model_mem [256];
    logic [15:0] dout_q;
    int          owner;   // -1 none, 0 or 1 holds the lock
    int          wait1;

    assign mem_dout = dout_q;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_we0) phys_mem[mem_addr[7:0]][7:0] <= mem_din[7:0];
        if (mem_we1) phys_mem[mem_addr[7:0]][15:8] <= mem_din[15:8];
        if (mem_oe) dout_q <= phys_mem[mem_addr[7:0]];
    end

    function automatic void check(input string name, input logic [31:0] act,
                                  input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
        end
    endfunction

    function automatic mreq_t idle_m();
        mreq_t t;
        t = '0;
        return t;
    endfunction

    function automatic mreq_t lock_only();
        mreq_t t;
        t = '0;
        t.lock = 1'b1;
        return t;
    endfunction

    function automatic mreq_t rd(input logic [15:0] a, input logic l);
        mreq_t t;
        t = '0;
        t.req = 1'b1; t.lock = l; t.oe = 1'b1; t.addr = a;
        return t;
    endfunction

    function automatic mreq_t wr(input logic [15:0] a, input logic [15:0] d,
                                 input logic [1:0] we, input logic oe);
        mreq_t t;
        t = '0;
        t.req = 1'b1; t.oe = oe; t.we = we; t.addr = a; t.wdata = d;
        return t;
    endfunction

    function automatic mreq_t rand_m();
        mreq_t t;
        int    kind;
        t = '0;
        t.req   = ($urandom_range(0, 9) < 7);
        t.lock  = ($urandom_range(0, 3) == 0);
        t.addr  = 16'($urandom_range(0, 255));
        t.wdata = 16'($urandom);
        kind    = $urandom_range(0, 9);
        if (kind < 6) begin
            t.oe = 1'b1;
        end else begin
            t.we = 2'($urandom_range(1, 3));
            t.oe = (kind == 9);
        end
        return t;
    endfunction

    // One clock cycle: drive, check combinational outputs, advance model.
    task automatic step(input bit r, input mreq_t a, input mreq_t b);
        bit    g0, g1, sat;
        mreq_t s;
        logic  oe_eff;
        rst = r;
        m0_req = a.req; m0_lock = a.lock; m0_oe = a.oe; m0_we = a.we;
        m0_addr = a.addr; m0_wdata = a.wdata;
        m1_req = b.req; m1_lock = b.lock; m1_oe = b.oe; m1_we = b.we;
        m1_addr = b.addr; m1_wdata = b.wdata;
        @(negedge clk);
        g0 = 0; g1 = 0;
        sat = Guard && b.req && (wait1 == int'(MaxWait));
        if (!r) begin
            if (owner == -1) begin
                if (sat) g1 = 1;
                else if (a.req) g0 = 1;
                else if (b.req) g1 = 1;
            end else if (owner == 0) begin
                if (sat) g1 = 1;
                else g0 = a.req;
            end else begin
                g1 = b.req;
            end
        end
        s = g1 ? b : (g0 ? a : idle_m());
        oe_eff = s.oe && (s.we == 2'b00);
        check("gnt", 32'({m1_gnt, m0_gnt}), 32'({g1, g0}));
        check("mem_addr", 32'(mem_addr), 32'(s.addr));
        check("mem_din", 32'(mem_din), 32'(s.wdata));
        check("mem_oe", 32'(mem_oe), 32'(oe_eff));
        check("mem_we", 32'({mem_we1, mem_we0}), 32'(s.we));
        if (oe_eff) sbq.push_back('{m: (g1 ? 1 : 0), data: model_mem[s.addr[7:0]], due: cyc + 1});
        if (s.we[0]) model_mem[s.addr[7:0]][7:0] = s.wdata[7:0];
        if (s.we[1]) model_mem[s.addr[7:0]][15:8] = s.wdata[15:8];
        if (r) owner = -1;
        else if (g0 && a.lock) owner = 0;
        else if (g1 && b.lock) owner = 1;
        else if (owner == 0 && g1) owner = -1;
        else if (owner == 0 && !a.lock) owner = -1;
        else if (owner == 1 && !b.lock) owner = -1;
        if (r || !b.req || g1) wait1 = 0;
        else if (wait1 < int'(MaxWait)) wait1 = wait1 + 1;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Monitor: consume scoreboard entries whenever a read is due.
    always @(negedge clk) begin
        if (started) begin
            if (rst) begin
                while (sbq.size() > 0 && sbq[0].due <= cyc) sbq.delete(0);
            end
            if (!rst && sbq.size() > 0 && sbq[0].due == cyc) begin
                mon_e = sbq[0];
                sbq.delete(0);
                check("rvalid", 32'({m1_rvalid, m0_rvalid}),
                      (mon_e.m == 1) ? 32'd2 : 32'd1);
                if (mon_e.m == 1) begin
                    check("m1_rdata", 32'(m1_rdata), 32'(mon_e.data));
                    check("m0_rdata_idle", 32'(m0_rdata), 32'd0);
                end else begin
                    check("m0_rdata", 32'(m0_rdata), 32'(mon_e.data));
                    check("m1_rdata_idle", 32'(m1_rdata), 32'd0);
                end
            end else begin
                check("rvalid_idle", 32'({m1_rvalid, m0_rvalid}), 32'd0);
                check("rdata_idle", 32'({m1_rdata, m0_rdata}), 32'd0);
            end
        end
    end

    initial begin
        rst = 1'b1;
        owner = -1;
        wait1 = 0;
        for (int i = 0; i < 256; i++) begin
            phys_mem[i]  = 16'(i * 16'h0101) ^ 16'h5A3C;
            model_mem[i] = 16'(i * 16'h0101) ^ 16'h5A3C;
        end
        phys_mem[8'h40]  = 16'hBEEF;
        model_mem[8'h40] = 16'hBEEF;
        dout_q  = 16'h0000;
        started = 1'b1;

        // Reset with both masters requesting, then m0 first after release.
        step(1, rd(16'h0010, 0), rd(16'h0020, 0));
        step(1, rd(16'h0010, 0), rd(16'h0020, 0));
        step(0, rd(16'h0010, 0), rd(16'h0020, 0));
        step(0, idle_m(), idle_m());

        // Read path.
        step(0, idle_m(), rd(16'h0040, 0));
        step(0, idle_m(), idle_m());

        // Byte write, illegal oe+we, then read back the byte-merged word.
        step(0, wr(16'h0003, 16'h12AB, 2'b01, 0), idle_m());
        step(0, wr(16'h0003, 16'h12AB, 2'b01, 1), idle_m());
        step(0, idle_m(), idle_m());
        step(0, rd(16'h0003, 0), idle_m());
        step(0, wr(16'h0005, 16'hC3D4, 2'b10, 0), idle_m());
        step(0, rd(16'h0005, 0), idle_m());

        // Lock: m1 owns the bus while m0 waits.
        step(0, idle_m(), rd(16'h0050, 1));
        for (int i = 0; i < 3; i++) step(0, rd(16'h0060, 0), lock_only());
        step(0, rd(16'h0060, 0), idle_m());
        step(0, rd(16'h0060, 0), idle_m());
        step(0, idle_m(), idle_m());

        // Continuous contention (starvation guard behaviour if enabled).
        for (int i = 0; i < 8; i++) step(0, rd(16'h0070, 0), rd(16'h0071, 0));
        step(0, idle_m(), idle_m());

        // Interleaved reads.
        step(0, rd(16'h0080, 0), idle_m());
        step(0, idle_m(), rd(16'h0081, 0));
        step(0, rd(16'h0082, 0), idle_m());
        step(0, idle_m(), rd(16'h0083, 0));
        step(0, idle_m(), idle_m());

        // Read accepted just before reset must not return.
        step(0, rd(16'h0090, 1), idle_m());
        step(1, idle_m(), idle_m());
        step(0, idle_m(), rd(16'h0091, 0));
        step(0, idle_m(), idle_m());

        // Random traffic.
        for (int i = 0; i < 500; i++) begin
            step(($urandom_range(0, 49) == 0), rand_m(), rand_m());
        end
        step(0, idle_m(), idle_m());
        step(0, idle_m(), idle_m());

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
